// File: rtl/switch_debounce.sv
// Debouncer for a raw mechanical switch: two-flop synchronizer followed by a
// four-state qualification FSM producing a clean level, edge pulses and a press count.
module switch_debounce #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch,
  output logic       o_Switch,
  output logic       o_Press,
  output logic       o_Release,
  output logic [7:0] o_Press_Count
);

  localparam int CNT_W = (DEBOUNCE_LIMIT < 1) ? 1 : $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LOW,
    PEND_HIGH,
    STABLE_HIGH,
    PEND_LOW
  } state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic             switch_q, switch_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [7:0]       count_q, count_d;

  // A commit needs sync2 to still hold the new level when the counter is full;
  // a reversion on that same edge drops back to the stable state instead.
  always_comb begin
    sync1_d   = i_Switch;
    sync2_d   = sync1_q;
    state_d   = state_q;
    counter_d = counter_q;
    switch_d  = switch_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;

    case (state_q)
      STABLE_LOW: begin
        if (sync2_q) begin
          state_d   = PEND_HIGH;
          counter_d = ONE;
        end else begin
          counter_d = '0;
        end
      end

      PEND_HIGH: begin
        if (!sync2_q) begin
          state_d   = STABLE_LOW;
          counter_d = '0;
        end else if (counter_q < LIMIT) begin
          counter_d = counter_q + ONE;
        end else begin
          state_d   = STABLE_HIGH;
          counter_d = '0;
          switch_d  = 1'b1;
          press_d   = 1'b1;
          count_d   = count_q + 8'd1;
        end
      end

      STABLE_HIGH: begin
        if (!sync2_q) begin
          state_d   = PEND_LOW;
          counter_d = ONE;
        end else begin
          counter_d = '0;
        end
      end

      PEND_LOW: begin
        if (sync2_q) begin
          state_d   = STABLE_HIGH;
          counter_d = '0;
        end else if (counter_q < LIMIT) begin
          counter_d = counter_q + ONE;
        end else begin
          state_d   = STABLE_LOW;
          counter_d = '0;
          switch_d  = 1'b0;
          release_d = 1'b1;
        end
      end

      default: begin
        state_d   = STABLE_LOW;
        counter_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= STABLE_LOW;
      counter_q <= '0;
      switch_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      counter_q <= counter_d;
      switch_q  <= switch_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

  assign o_Switch      = switch_q;
  assign o_Press       = press_q;
  assign o_Release     = release_q;
  assign o_Press_Count = count_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: two instances (limit 4 and limit 1) share one stimulus;
// a sliding-window model predicts every output each cycle, plus literal timing pins.
module tb_switch_debounce;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Switch = 1'b0;

  logic       sw4, pr4, rl4;
  logic [7:0] cnt4;
  logic       sw1, pr1, rl1;
  logic [7:0] cnt1;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  switch_debounce #(.DEBOUNCE_LIMIT(4)) dut_l4 (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch),
    .o_Switch(sw4), .o_Press(pr4), .o_Release(rl4), .o_Press_Count(cnt4)
  );

  switch_debounce #(.DEBOUNCE_LIMIT(1)) dut_l1 (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Switch(i_Switch),
    .o_Switch(sw1), .o_Press(pr1), .o_Release(rl1), .o_Press_Count(cnt1)
  );

  always #5 i_Clk = ~i_Clk;

  // Model: the level flips on an edge exactly when the last LIMIT+1 synchronized
  // samples all disagree with the current level; synchronized = raw delayed 2 edges.
  int         lim [2] = '{4, 1};
  logic       r1 = 1'b0, r2 = 1'b0;
  logic       hist [2][0:7];
  logic       m_sw [2] = '{1'b0, 1'b0};
  logic       m_pr [2] = '{1'b0, 1'b0};
  logic       m_rl [2] = '{1'b0, 1'b0};
  logic [7:0] m_cnt [2] = '{8'd0, 8'd0};

  initial begin
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 8; k++) hist[i][k] = 1'b0;
    forever begin
      @(posedge i_Clk or negedge i_Rst_L);
      if (!i_Rst_L) begin
        r1 = 1'b0;
        r2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
          for (int k = 0; k < 8; k++) hist[i][k] = 1'b0;
          m_sw[i] = 1'b0; m_pr[i] = 1'b0; m_rl[i] = 1'b0; m_cnt[i] = 8'd0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          bit all_differ;
          for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
          hist[i][0] = r2;
          all_differ = 1'b1;
          for (int k = 0; k <= lim[i]; k++)
            if (hist[i][k] == m_sw[i]) all_differ = 1'b0;
          m_pr[i] = 1'b0;
          m_rl[i] = 1'b0;
          if (all_differ) begin
            m_sw[i] = !m_sw[i];
            if (m_sw[i]) begin
              m_pr[i]  = 1'b1;
              m_cnt[i] = m_cnt[i] + 8'd1;
            end else begin
              m_rl[i] = 1'b1;
            end
          end
        end
        r2 = r1;
        r1 = i_Switch;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge i_Clk);
      if (cmp_en) begin
        checkOutput("model_sw4",  8'(sw4),  8'(m_sw[0]));
        checkOutput("model_pr4",  8'(pr4),  8'(m_pr[0]));
        checkOutput("model_rl4",  8'(rl4),  8'(m_rl[0]));
        checkOutput("model_cnt4", cnt4,     m_cnt[0]);
        checkOutput("model_sw1",  8'(sw1),  8'(m_sw[1]));
        checkOutput("model_pr1",  8'(pr1),  8'(m_pr[1]));
        checkOutput("model_rl1",  8'(rl1),  8'(m_rl[1]));
        checkOutput("model_cnt1", cnt1,     m_cnt[1]);
      end
    end
  end

  task automatic applyStimulus(input logic v);
    @(negedge i_Clk);
    #1 i_Switch = v;
  endtask

  task automatic setReset(input logic v);
    @(negedge i_Clk);
    #1 i_Rst_L = v;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic holdLevel(input logic v, input int n);
    applyStimulus(v);
    repeat (n) @(posedge i_Clk);
  endtask

  initial begin
    cmp_en = 1'b1;
    waitEdges(3);
    checkOutput("reset_sw4", 8'(sw4), 8'd0);
    checkOutput("reset_pr4", 8'(pr4), 8'd0);
    checkOutput("reset_cnt4", cnt4, 8'd0);
    setReset(1'b1);
    waitEdges(5);

    // Clean press: limit-1 instance commits after 4 edges, limit-4 after 7
    applyStimulus(1'b1);
    waitEdges(3);
    checkOutput("l1_press_early", 8'(pr1), 8'd0);
    waitEdges(1);
    checkOutput("l1_press", 8'(pr1), 8'd1);
    checkOutput("l1_cnt", cnt1, 8'd1);
    waitEdges(2);
    checkOutput("press_early_pr", 8'(pr4), 8'd0);
    checkOutput("press_early_sw", 8'(sw4), 8'd0);
    waitEdges(1);
    checkOutput("press_pr", 8'(pr4), 8'd1);
    checkOutput("press_sw", 8'(sw4), 8'd1);
    checkOutput("press_cnt", cnt4, 8'd1);
    waitEdges(1);
    checkOutput("press_single", 8'(pr4), 8'd0);
    waitEdges(4);

    // Release
    applyStimulus(1'b0);
    waitEdges(6);
    checkOutput("release_early_rl", 8'(rl4), 8'd0);
    checkOutput("release_early_sw", 8'(sw4), 8'd1);
    waitEdges(1);
    checkOutput("release_rl", 8'(rl4), 8'd1);
    checkOutput("release_sw", 8'(sw4), 8'd0);
    checkOutput("release_pr", 8'(pr4), 8'd0);
    waitEdges(1);
    checkOutput("release_single", 8'(rl4), 8'd0);
    waitEdges(4);

    // Bounce: 3 high, 1 low, 3 high, low -- never 5 consecutive samples
    holdLevel(1'b1, 3);
    holdLevel(1'b0, 1);
    holdLevel(1'b1, 3);
    holdLevel(1'b0, 10);
    #1;
    checkOutput("bounce_sw4", 8'(sw4), 8'd0);
    checkOutput("bounce_cnt4", cnt4, 8'd1);
    checkOutput("bounce_cnt1", cnt1, 8'd2);

    // One-clock glitch must not register on the limit-1 instance
    holdLevel(1'b1, 1);
    holdLevel(1'b0, 10);
    #1;
    checkOutput("glitch_sw1", 8'(sw1), 8'd0);
    checkOutput("glitch_cnt1", cnt1, 8'd2);

    // Reset while limit-4 instance is pending with counter at 3
    applyStimulus(1'b1);
    waitEdges(5);
    i_Rst_L = 1'b0;
    #1;
    checkOutput("midrst_sw4", 8'(sw4), 8'd0);
    checkOutput("midrst_pr4", 8'(pr4), 8'd0);
    checkOutput("midrst_rl4", 8'(rl4), 8'd0);
    checkOutput("midrst_cnt4", cnt4, 8'd0);
    checkOutput("midrst_cnt1", cnt1, 8'd0);
    waitEdges(2);
    setReset(1'b1);
    waitEdges(6);
    checkOutput("postrst_early", 8'(pr4), 8'd0);
    waitEdges(1);
    checkOutput("postrst_pr", 8'(pr4), 8'd1);
    checkOutput("postrst_cnt", cnt4, 8'd1);
    applyStimulus(1'b0);
    waitEdges(10);

    // Wrap-around of the press counter over 256 presses
    setReset(1'b0);
    waitEdges(2);
    setReset(1'b1);
    waitEdges(2);
    for (int k = 0; k < 256; k++) begin
      applyStimulus(1'b1);
      waitEdges(7);
      checkOutput("wrap_pr", 8'(pr4), 8'd1);
      checkOutput("wrap_cnt", cnt4, 8'(k + 1));
      waitEdges(2);
      applyStimulus(1'b0);
      waitEdges(9);
    end
    checkOutput("wrap_final4", cnt4, 8'd0);
    checkOutput("wrap_final1", cnt1, 8'd0);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
